des_round_ctrl: RTL

- Sequencer for the iterative DES round datapath: expansion, key XOR, S-box and P-box stages plus the per-round key schedule.
- Accepts a start request and asserts a one-cycle load strobe for the IP/initial key.
- Then issues 16 round launches with round index and key-shift amount. Each launch waits for the datapath's round-complete valid before the next.
- Finishes with a final-swap/FP strobe and a done pulse.
- Sits between the top-level DES wrapper and the round pipeline (ext/xor/sbox/pbox registers).

---
 rtl/des_round_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/des_round_ctrl.sv
// Sequencer for the iterative DES round datapath: load strobe, 16 round launches, final/FP strobe, done pulse.
// Optional WAIT timeout enabled by defining DES_ROUND_TIMEOUT_EN.
module des_round_ctrl #(
  parameter int NUM_ROUNDS     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       start_in,
  input  logic       decrypt_in,
  input  logic       abort_in,
  input  logic       round_done_in,
  output logic       ready_out,
  output logic       busy_out,
  output logic       load_out,
  output logic       round_valid_out,
  output logic [3:0] round_idx_out,
  output logic [1:0] key_shift_out,
  output logic       key_dir_out,
  output logic       final_out,
  output logic       done_out,
  output logic       err_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_FINAL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mode, mode_nxt;
  logic       last_round;
  logic       timeout_hit;

  assign last_round = (cnt == 4'(NUM_ROUNDS - 1));

  // Decrypt round 0 uses the unrotated key; otherwise both directions share one schedule.
  function automatic logic [1:0] shift_of(input logic [3:0] r, input logic dec);
    logic [1:0] s;
    case (r)
      4'd0:               s = dec ? 2'd0 : 2'd1;
      4'd1, 4'd8, 4'd15:  s = 2'd1;
      default:            s = 2'd2;
    endcase
    return s;
  endfunction

`ifdef DES_ROUND_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wait_cnt;
  logic          err_q;

  assign timeout_hit = (state == S_WAIT) && !round_done_in &&
                       (wait_cnt == WW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout_hit && !abort_in;
      if (state == S_ISSUE)
        wait_cnt <= '0;
      else if (state == S_WAIT && !round_done_in)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign err_out = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_out     = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      mode  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      mode  <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode;
    if (abort_in && state != S_IDLE) begin
      state_nxt = S_IDLE;
      cnt_nxt   = 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_in && !abort_in) begin
            state_nxt = S_LOAD;
            cnt_nxt   = 4'd0;
            mode_nxt  = decrypt_in;
          end
        end
        S_LOAD:  state_nxt = S_ISSUE;
        S_ISSUE: state_nxt = S_WAIT;
        S_WAIT: begin
          if (round_done_in) begin
            if (last_round) begin
              state_nxt = S_FINAL;
            end else begin
              state_nxt = S_ISSUE;
              cnt_nxt   = cnt + 4'd1;
            end
          end else if (timeout_hit) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
          end
        end
        S_FINAL: state_nxt = S_DONE;
        S_DONE: begin
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  assign ready_out       = (state == S_IDLE);
  assign busy_out        = (state != S_IDLE);
  assign load_out        = (state == S_LOAD);
  assign round_valid_out = (state == S_ISSUE);
  assign final_out       = (state == S_FINAL);
  assign done_out        = (state == S_DONE);
  assign round_idx_out   = cnt;
  assign key_shift_out   = busy_out ? shift_of(cnt, mode) : 2'd0;
  assign key_dir_out     = mode;

endmodule
